// File: rtl/seg7_display_ctrl_if.sv
// Handshake bundle carrying signed products into the 7-segment sequencer.
`timescale 1ns/1ps
interface seg7_display_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seg7_display_ctrl.sv
// Display-bank sequencer: takes a signed value, converts its magnitude to BCD
// with a bit-serial double-dabble, then formats the digit codes with
// leading-zero blanking and a minus sign (0-9 digit, A '-', F blank).
`timescale 1ns/1ps
module seg7_display_ctrl #(
  parameter int W    = 16,
  parameter int NDIG = 6
) (
  input  logic              clk,
  input  logic              rst,
  seg7_display_ctrl_if.slave in_bus,
  output logic [4*NDIG-1:0] digits_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int BW = 4 * (NDIG - 1);
  localparam int CW = $clog2(W + 1);

  // Number of decimal digits in 2^(W-1), the largest magnitude we can receive.
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = longint'(1) << (w - 1);
    n = 0;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  if (NDIG < dec_digits(W) + 1) begin : g_ndig_check
    $error("seg7_display_ctrl: NDIG=%0d too small for W=%0d", NDIG, W);
  end

  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

  state_t              state, state_next;
  logic                sign;
  logic [W-1:0]        mag;
  logic [BW-1:0]       bcd, bcd_adj, bcd_shift;
  logic [CW-1:0]       bit_cnt;
  logic [W-1:0]        abs_in;
  logic [4*NDIG-1:0]   fmt;
  logic                accept;
  int                  msd;

  // An unsigned W-bit magnitude already holds 2^(W-1) exactly, so the most
  // negative input needs no extra bit here.
  assign abs_in = in_bus.in_data[W-1] ? (~in_bus.in_data + W'(1)) : in_bus.in_data;
  assign accept = (state == IDLE) && in_bus.in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus handshake/busy outputs decoded from the state.
  always_comb begin
    state_next      = state;
    in_bus.in_ready = 1'b0;
    busy_o          = 1'b0;
    unique case (state)
      IDLE: begin
        in_bus.in_ready = 1'b1;
        if (in_bus.in_valid) state_next = CONV;
      end
      CONV: begin
        busy_o = 1'b1;
        if (bit_cnt == CW'(W - 1)) state_next = FMT;
      end
      FMT: begin
        busy_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NDIG - 1; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    bcd_shift = (bcd_adj << 1) | BW'(mag[W-1]);
  end

  // Blank everything above the most-significant nonzero digit and place the sign next to it.
  always_comb begin
    msd = 0;
    for (int k = 0; k < NDIG - 1; k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd = k;
    end
    fmt = '1;
    for (int k = 0; k < NDIG - 1; k++) begin
      if (k <= msd)                     fmt[4*k +: 4] = bcd[4*k +: 4];
      else if (sign && (k == msd + 1))  fmt[4*k +: 4] = 4'hA;
    end
    if (sign && (msd == NDIG - 2)) fmt[4*NDIG-4 +: 4] = 4'hA;
  end

  // Datapath: capture on accept, iterate during CONV, publish digits on FMT exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_o <= '1;
      done_o   <= 1'b0;
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign    <= in_bus.in_data[W-1];
            mag     <= abs_in;
            bcd     <= '0;
            bit_cnt <= '0;
          end
        end
        CONV: begin
          bcd     <= bcd_shift;
          mag     <= mag << 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
        FMT: begin
          digits_o <= fmt;
          done_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: a cycle-level behavioural model
// predicts every output each cycle, and literal values pin key results.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;
  localparam int W    = 16;
  localparam int NDIG = 6;
  localparam int LAT  = W + 1;

  logic              clk;
  logic              rst;
  logic [4*NDIG-1:0] digits_o;
  logic              done_o;
  logic              busy_o;

  seg7_display_ctrl_if #(.W(W)) bus();

  seg7_display_ctrl #(.W(W), .NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bus   (bus),
    .digits_o (digits_o),
    .done_o   (done_o),
    .busy_o   (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit                model_live    = 0;
  bit                model_pending = 0;
  int                model_count   = 0;
  int                model_value   = 0;
  bit                model_done    = 0;
  logic [4*NDIG-1:0] model_digits  = '1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Decimal rendering of a signed value as display codes, rightmost display = units.
  function automatic logic [4*NDIG-1:0] format_value(input int v);
    logic [4*NDIG-1:0] r;
    longint            a;
    int                pos;
    r   = '1;
    a   = (v < 0) ? -longint'(v) : longint'(v);
    pos = 0;
    do begin
      r[4*pos +: 4] = 4'(a % 10);
      a = a / 10;
      pos++;
    end while (a != 0);
    if (v < 0) r[4*pos +: 4] = 4'hA;
    return r;
  endfunction

  // Behavioural model: a result appears LAT edges after an accepted value.
  always @(posedge clk) begin
    if (rst) begin
      model_pending = 0;
      model_done    = 0;
      model_digits  = '1;
    end else begin
      model_done = 0;
      if (model_pending) begin
        model_count--;
        if (model_count == 0) begin
          model_digits  = format_value(model_value);
          model_done    = 1;
          model_pending = 0;
        end
      end else if (bus.in_valid) begin
        model_pending = 1;
        model_count   = LAT;
        model_value   = int'($signed(bus.in_data));
      end
    end
    model_live = 1;
  end

  // Every cycle: all DUT outputs must match the model.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("digits", 64'(digits_o), 64'(model_digits));
      checkOutput("done", 64'(done_o), 64'(model_done));
      checkOutput("busy", 64'(busy_o), 64'(model_pending));
      checkOutput("ready", 64'(bus.in_ready), 64'(!model_pending));
    end
  end

  // Wait (bounded) for the done pulse, scrambling inputs while busy.
  task automatic waitDone(input string name, input bit hold_valid, input bit next_valid,
                          input logic [W-1:0] next_data);
    bit got;
    got = 0;
    for (int i = 0; i < 2 * LAT + 4 && !got; i++) begin
      @(negedge clk);
      if (done_o) begin
        got          = 1;
        bus.in_valid = next_valid;
        bus.in_data  = next_data;
      end else begin
        bus.in_data  = W'($urandom);
        bus.in_valid = hold_valid ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
    end
    checkOutput({name, "_done_seen"}, 64'(got), 64'd1);
  endtask

  // Send one value, wait for its result, optionally pin it to a literal.
  task automatic applyStimulus(input logic [W-1:0] val, input logic [4*NDIG-1:0] lit,
                               input bit use_lit, input string name);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    @(negedge clk);
    checkOutput({name, "_accepted"}, 64'(busy_o), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    waitDone(name, 1'b0, 1'b0, W'($urandom));
    if (use_lit) checkOutput({name, "_lit"}, 64'(digits_o), 64'(lit));
  endtask

  initial begin
    bit            seen;
    logic [W-1:0]  v;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_digits", 64'(digits_o), 64'hFFFFFF);
    checkOutput("reset_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    applyStimulus(W'(0),      24'hFFFFF0, 1, "zero");
    applyStimulus(W'(1234),   24'hFF1234, 1, "p1234");
    applyStimulus(16'hFFFF,   24'hFFFFA1, 1, "m1");
    applyStimulus(W'(-905),   24'hFFA905, 1, "m905");
    applyStimulus(16'h8000,   24'hA32768, 1, "min");
    applyStimulus(16'h7FFF,   24'hF32767, 1, "max");

    // Back-to-back with in_valid held high: 7 then -40.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(7);
    waitDone("b2b_first", 1'b1, 1'b1, W'(-40));
    checkOutput("b2b_first_lit", 64'(digits_o), 64'hFFFFF7);
    @(negedge clk);
    checkOutput("b2b_second_accepted", 64'(busy_o), 64'd1);
    bus.in_data = W'($urandom);
    waitDone("b2b_second", 1'b1, 1'b0, W'(0));
    checkOutput("b2b_second_lit", 64'(digits_o), 64'hFFFA40);

    // Abort: accept 999, reset sampled on CONV edge 5.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(999);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_digits", 64'(digits_o), 64'hFFFFFF);
    checkOutput("abort_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    checkOutput("abort_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    checkOutput("abort_no_done", 64'(seen), 64'd0);

    // Randomized values with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       v = 16'h8000;
        1:       v = W'($urandom_range(0, 9));
        2:       v = W'(-$urandom_range(1, 99));
        default: v = W'($urandom);
      endcase
      applyStimulus(v, '1, 0, "rand");
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.in_data = W'($urandom);
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
